// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words, writes them to
// instruction memory, and holds the core in reset until the whole image has been written.
module imem_boot_loader #(
    parameter int          N           = 64,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter int unsigned TIMEOUT     = 65535
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic         imem_we,
    output logic [N-1:0] imem_addr,
    output logic [31:0]  imem_wdata,
    output logic         core_rst,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [15:0]  words_loaded
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    localparam logic [N-1:0] BASE = BASE_ADDR[N-1:0];

    logic [2:0]   state_q, state_d;
    logic [31:0]  len_q, len_d;
    logic [31:0]  shift_q, shift_d;
    logic [1:0]   byte_cnt_q, byte_cnt_d;
    logic [31:0]  idle_q, idle_d;
    logic [15:0]  words_loaded_q, words_loaded_d;
    logic         imem_we_q, imem_we_d;
    logic [N-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]  imem_wdata_q, imem_wdata_d;
    logic         core_rst_q, core_rst_d;

    logic         hs;
    logic [31:0]  next_word;
    logic         last_write;
    logic         timed_out;

    assign in_ready   = (state_q == S_LEN) || (state_q == S_DATA);
    assign hs         = in_ready && in_valid;
    assign next_word  = {in_data, shift_q[31:8]};
    // The final word's write cycle ends the load; a byte offered then is not part of the image.
    assign last_write = (state_q == S_DATA) && imem_we_q && ({16'd0, words_loaded_q} == len_q);
    assign timed_out  = (TIMEOUT != 0) && !hs && ((idle_q + 32'd1) == TIMEOUT);

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        shift_d        = shift_q;
        byte_cnt_d     = byte_cnt_q;
        idle_d         = idle_q;
        words_loaded_d = words_loaded_q;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        core_rst_d     = core_rst_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d        = S_LEN;
                    shift_d        = '0;
                    byte_cnt_d     = '0;
                    idle_d         = '0;
                    words_loaded_d = '0;
                    core_rst_d     = 1'b1;
                end
            end
            S_LEN, S_DATA: begin
                idle_d = hs ? '0 : idle_q + 32'd1;
                if (last_write) begin
                    state_d    = S_DONE;
                    core_rst_d = 1'b0;
                end else if (timed_out) begin
                    state_d = S_ERROR;
                end else if (hs) begin
                    shift_d    = next_word;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (state_q == S_LEN) begin
                            len_d   = next_word;
                            state_d = (next_word == 32'd0 || next_word > 32'(DEPTH_WORDS))
                                      ? S_ERROR : S_DATA;
                        end else begin
                            imem_we_d      = 1'b1;
                            imem_wdata_d   = next_word;
                            imem_addr_d    = BASE + (N'(words_loaded_q) << 2);
                            words_loaded_d = words_loaded_q + 16'd1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            len_q          <= '0;
            shift_q        <= '0;
            byte_cnt_q     <= '0;
            idle_q         <= '0;
            words_loaded_q <= '0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
            core_rst_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            shift_q        <= shift_d;
            byte_cnt_q     <= byte_cnt_d;
            idle_q         <= idle_d;
            words_loaded_q <= words_loaded_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            core_rst_q     <= core_rst_d;
        end
    end

    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign core_rst     = core_rst_q;
    assign busy         = in_ready;
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERROR);
    assign words_loaded = words_loaded_q;

endmodule
